// File: rtl/systolic_skew_feeder.sv
// Operand feeder for the 16x16 output-stationary array: lane i of A and B is delayed i cycles.
// After k_len slices it streams zeros until every PE sum is final, then pulses done for one cycle.
module systolic_skew_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int SIZE       = 16,
  parameter int K_WIDTH    = 8,
  parameter int PE_LAT     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [K_WIDTH-1:0]         k_len,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SIZE*DATA_WIDTH-1:0] a_col,
  input  logic [SIZE*DATA_WIDTH-1:0] b_row,
  output logic [SIZE*DATA_WIDTH-1:0] left_out,
  output logic [SIZE*DATA_WIDTH-1:0] top_out,
  output logic                       busy,
  output logic                       done
);

  // The last operand pair reaches PE(SIZE-1,SIZE-1) after 2*(SIZE-1) hops; add the PE latency.
  localparam int DRAIN_CYC = 2 * (SIZE - 1) + PE_LAT;
  localparam int DC_W      = $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [K_WIDTH-1:0] k_len_q, k_len_d;
  logic [K_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [DC_W-1:0]    drain_cnt_q, drain_cnt_d;
  logic               accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_len_q     <= '0;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    beat_cnt_d  = beat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    in_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (k_len != '0) begin
            k_len_d    = k_len;
            beat_cnt_d = '0;
            state_d    = S_STREAM;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_STREAM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          beat_cnt_d = beat_cnt_q + K_WIDTH'(1);
          if (beat_cnt_q == k_len_q - K_WIDTH'(1)) begin
            drain_cnt_d = '0;
            state_d     = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_cnt_q == DC_W'(DRAIN_CYC - 1)) begin
          state_d = S_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + DC_W'(1);
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  // Idle cycles inject zeros, which the PEs accumulate harmlessly as 0*x.
  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] a_q [0:i];
    logic [DATA_WIDTH-1:0] b_q [0:i];
    logic [DATA_WIDTH-1:0] a_d, b_d;

    assign a_d = accept ? a_col[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign b_d = accept ? b_row[i*DATA_WIDTH +: DATA_WIDTH] : '0;

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k <= i; k++) begin
          a_q[k] <= '0;
          b_q[k] <= '0;
        end
      end else begin
        a_q[0] <= a_d;
        b_q[0] <= b_d;
        for (int k = 1; k <= i; k++) begin
          a_q[k] <= a_q[k-1];
          b_q[k] <= b_q[k-1];
        end
      end
    end

    assign left_out[i*DATA_WIDTH +: DATA_WIDTH] = a_q[i];
    assign top_out[i*DATA_WIDTH +: DATA_WIDTH]  = b_q[i];
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder: per-cycle expected skew slots and a done-cycle queue,
// plus a behavioural 16x16 output-stationary array fed from the DUT outputs.
module tb_systolic_skew_feeder;

  localparam int DW = 8;
  localparam int N  = 16;
  localparam int W  = N * DW;
  localparam int DRAIN = 31;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [7:0]   k_len;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_col, b_row;
  logic [W-1:0] left_out, top_out;
  logic         busy, done;

  systolic_skew_feeder dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_col(a_col), .b_row(b_row),
    .left_out(left_out), .top_out(top_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;
  int last_done_cyc = -1;

  logic [W-1:0] exp_l [64];
  logic [W-1:0] exp_t [64];
  int           done_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    chk_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else
      pass_cnt++;
  endtask

  // Monitor: compares skewed buses against the slot filled when the beat was issued.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("left_out", left_out, exp_l[cyc % 64]);
      chk("top_out", top_out, exp_t[cyc % 64]);
      exp_l[cyc % 64] = '0;
      exp_t[cyc % 64] = '0;
      if (done === 1'b1) begin
        last_done_cyc = cyc;
        if (done_q.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          chk("done_cycle", cyc, done_q.pop_front());
        end
      end
    end
  end

  // Behavioural output-stationary array driven by left_out/top_out.
  int          acc [N][N];
  logic [7:0]  ah  [N][N];
  logic [7:0]  bv  [N][N];
  bit          arr_clr = 1'b0;

  always @(posedge clk) begin
    for (int i = N - 1; i >= 0; i--) begin
      for (int j = N - 1; j >= 0; j--) begin
        logic [7:0] a_in, b_in;
        if (j == 0) a_in = left_out[i*DW +: DW];
        else        a_in = ah[i][j-1];
        if (i == 0) b_in = top_out[j*DW +: DW];
        else        b_in = bv[i-1][j];
        if (arr_clr) begin
          acc[i][j] = 0;
          ah[i][j]  = '0;
          bv[i][j]  = '0;
        end else begin
          acc[i][j] = acc[i][j] + int'(a_in) * int'(b_in);
          ah[i][j]  = a_in;
          bv[i][j]  = b_in;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [7:0] kl, output int e);
    start = 1'b1;
    k_len = kl;
    step();
    e = cyc;
    start = 1'b0;
  endtask

  // Drives one beat; the accepting edge is the next one, so expected slots are keyed from cyc+1.
  task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b, output int e);
    chk("in_ready_stream", W'(in_ready), W'(1));
    chk("busy_stream", W'(busy), W'(1));
    e = cyc + 1;
    for (int i = 0; i < N; i++) begin
      exp_l[(e + i) % 64][i*DW +: DW] = a[i*DW +: DW];
      exp_t[(e + i) % 64][i*DW +: DW] = b[i*DW +: DW];
    end
    in_valid = 1'b1;
    a_col = a;
    b_row = b;
    step();
    in_valid = 1'b0;
    a_col = '0;
    b_row = '0;
  endtask

  task automatic gap();
    chk("in_ready_gap", W'(in_ready), W'(1));
    in_valid = 1'b1;
    in_valid = 1'b0;
    step();
  endtask

  task automatic wait_cycles(input int n);
    for (int c = 0; c < n; c++) step();
    chk("done_pending", W'(done_q.size()), W'(0));
  endtask

  task automatic clear_array();
    arr_clr = 1'b1;
    step();
    arr_clr = 1'b0;
  endtask

  task automatic check_array(input string name);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk(name, W'(acc[i][j]), W'(i + j));
  endtask

  // Identity A, B slice k lane j = k+j, optionally with a stall after every beat.
  task automatic ident_job(input bit stalls, output int s, output int d);
    int e;
    logic [W-1:0] a, b;
    clear_array();
    start_job(8'd16, s);
    for (int k = 0; k < N; k++) begin
      a = '0;
      for (int l = 0; l < N; l++) b[l*DW +: DW] = 8'(k + l);
      a[k*DW +: DW] = 8'h01;
      beat(a, b, e);
      if (stalls && k != N - 1) gap();
    end
    done_q.push_back(e + DRAIN);
    wait_cycles(40);
    d = last_done_cyc;
  endtask

  initial begin
    int e, s2, d2, s3, d3;
    logic [W-1:0] ones;
    for (int i = 0; i < 64; i++) begin
      exp_l[i] = '0;
      exp_t[i] = '0;
    end
    rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; a_col = '0; b_row = '0;
    step();
    mon_en = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready", W'(in_ready), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    wait_cycles(5);

    // Single all-ones beat: lane i pulses only in cycle t+i, done at t+31.
    ones = '0;
    for (int i = 0; i < N; i++) ones[i*DW +: DW] = 8'h01;
    start_job(8'd1, e);
    beat(ones, ones, e);
    chk("k1_in_ready_drain", W'(in_ready), W'(0));
    done_q.push_back(e + DRAIN);
    wait_cycles(40);

    ident_job(1'b0, s2, d2);
    check_array("array_b2b");
    ident_job(1'b1, s3, d3);
    check_array("array_stall");
    chk("stall_delay", W'((d3 - s3) - (d2 - s2)), W'(15));

    // k_len = 0 goes straight to DONE.
    start_job(8'd0, e);
    done_q.push_back(e);
    chk("k0_in_ready", W'(in_ready), W'(0));
    chk("k0_busy", W'(busy), W'(0));
    step();
    chk("k0_in_ready2", W'(in_ready), W'(0));
    wait_cycles(3);

    // Start during STREAM must not reload k_len.
    start_job(8'd3, e);
    beat({N{8'h11}}, {N{8'h22}}, e);
    start = 1'b1; k_len = 8'd5;
    gap();
    start = 1'b0;
    beat({N{8'h33}}, {N{8'h44}}, e);
    beat({N{8'h55}}, {N{8'h66}}, e);
    chk("restart_in_ready", W'(in_ready), W'(0));
    chk("restart_busy", W'(busy), W'(1));
    done_q.push_back(e + DRAIN);
    wait_cycles(40);

    // Reset mid-DRAIN: no done, clean follow-up job.
    start_job(8'd2, e);
    beat({N{8'h0f}}, {N{8'hf0}}, e);
    beat({N{8'h5a}}, {N{8'ha5}}, e);
    for (int c = 0; c < 20; c++) step();
    chk("pre_rst_busy", W'(busy), W'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_in_ready", W'(in_ready), W'(0));
    chk("midrst_busy", W'(busy), W'(0));
    chk("midrst_done", W'(done), W'(0));
    chk("midrst_left", left_out, '0);
    chk("midrst_top", top_out, '0);
    wait_cycles(15);
    start_job(8'd1, e);
    beat({N{8'h7e}}, {N{8'h81}}, e);
    done_q.push_back(e + DRAIN);
    wait_cycles(40);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
